fifo_sync_rd_stream: RTL and testbench

- Read-side adapter for the synchronous standard FIFO (registered read data, one cycle after an accepted rd_en).
- Drives the FIFO read port and presents its contents as a valid/ready stream with first-word-fall-through semantics.
- Sustains one word per cycle under continuous out_ready, with no bubbles.
- Sits between any fifo_sync_standard instance and a downstream valid/ready consumer, e.g. NoC link or debug packetizer.

---
 rtl/fifo_sync_rd_stream.sv | 87 ++++++++
 tb/tb_fifo_sync_rd_stream.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_rd_stream.sv
// Read-side adapter for a synchronous standard FIFO.
// The FIFO returns data one cycle after an accepted read. This block turns that
// into a first-word-fall-through valid/ready stream. It uses a 2-entry buffer:
// head drives out_data, and tail is the skid slot. Reads are issued against a
// credit of 2, so a word that is already in flight always has somewhere to land.
module fifo_sync_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       count;
  logic             inflight;
  logic             pop;
  logic [2:0]       credit;

  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign occupancy = count + {1'b0, inflight};

  // Issue a read only when the word will fit after this cycle's pop.
  // pop implies count >= 1, so the 3-bit sum never underflows.
  always_comb begin
    pop        = out_valid & out_ready;
    credit     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en = ~fifo_empty & ~rst & (credit < 3'd2);
  end

  // Buffer update: capture the returning word and/or shift on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        case (count)
          2'd0: begin
            head  <= fifo_dout;
            count <= 2'd1;
          end
          2'd1: begin
            if (pop) begin
              head <= fifo_dout;
            end else begin
              tail  <= fifo_dout;
              count <= 2'd2;
            end
          end
          default: begin
            // Only reachable with pop; the credit check rules out the no-pop case.
            head <= tail;
            tail <= fifo_dout;
          end
        endcase
      end else if (pop) begin
        if (count == 2'd2) begin
          head  <= tail;
          count <= 2'd1;
        end else begin
          count <= 2'd0;
        end
      end
    end
  end

  // A capture into a full buffer without a pop would drop a word.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inflight && (count == 2'd2) && !pop));

  // Every read request must target a non-empty FIFO.
  a_no_empty_read: assert property (@(posedge clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));

endmodule

// File: tb/tb_fifo_sync_rd_stream.sv
// Directed + random bench for fifo_sync_rd_stream, with a behavioural
// synchronous FIFO (registered read data) feeding it and a scoreboard on the stream.
module tb_fifo_sync_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] occupancy;

  fifo_sync_rd_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: pushes from the stimulus, pops on fifo_rd_en.
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fq.pop_front();
      rd_cnt    <= rd_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int rd_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    exp_q.push_back(d);
    wr_cnt++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_occ"},   32'(occupancy), 32'd0);
  endtask

  // Stream monitor, sampled mid-cycle after inputs settle.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (fifo_rd_en) rd_pulses++;
      chk("occ_le_2", 32'(occupancy <= 2'd2), 32'd1);
      chk("no_empty_read", 32'(fifo_rd_en && fifo_empty), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_extra_word", 32'(out_data), 32'hFFFF_FFFF);
        else chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    prev_hold = !rst && out_valid && !out_ready;
    prev_data = out_data;
  end

  int base;
  int pushed;
  int n;

  initial begin
    // Reset with a non-empty FIFO
    rst = 1'b1;
    out_ready = 1'b0;
    push(8'h77);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk_idle("rst");
    end
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_data", 32'(out_data), 32'd0);
    chk_idle("post_rst");
    chk("post_rst_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge clk); #1;
    chk("rst_word_occ", 32'(occupancy), 32'd1);
    chk("rst_word_nvalid", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    chk("rst_word_valid", 32'(out_valid), 32'd1);
    chk("rst_word_data", 32'(out_data), 32'h77);
    @(negedge clk); #1;
    chk("rst_word_held", 32'(out_data), 32'h77);
    @(negedge clk); out_ready = 1'b1; #1;
    @(negedge clk); #1;
    chk_idle("rst_word_done");

    // Single word
    @(negedge clk); base = rd_pulses; push(8'hA5); #1;
    chk("single_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge clk); #1;
    chk("single_rd_en_off", 32'(fifo_rd_en), 32'd0);
    chk("single_inflight_occ", 32'(occupancy), 32'd1);
    chk("single_nvalid", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    @(negedge clk); #1;
    chk_idle("single_done");
    chk("single_reads", 32'(rd_pulses - base), 32'd1);

    // Streaming 16 words at full rate
    @(negedge clk); base = rd_pulses;
    for (int i = 0; i < 16; i++) push(8'(i));
    #1;
    @(negedge clk); #1;
    chk("stream_lat_nvalid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", 32'(out_data), 32'(i));
    end
    @(negedge clk); #1;
    chk_idle("stream_done");
    chk("stream_reads", 32'(rd_pulses - base), 32'd16);

    // Backpressure
    @(negedge clk); out_ready = 1'b0; base = rd_pulses;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    #1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data_held", 32'(out_data), 32'h10);
    end
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_reads", 32'(rd_pulses - base), 32'd2);
    chk("bp_fifo_left", 32'(wr_cnt - rd_cnt), 32'd2);
    chk("bp_rd_en_off", 32'(fifo_rd_en), 32'd0);
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("bp_drain_valid", 32'(out_valid), 32'd1);
      chk("bp_drain_data", 32'(out_data), 32'(8'h10 + i));
    end
    @(negedge clk); #1;
    chk_idle("bp_done");

    // Reset mid-stream with one word buffered and one in flight
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    #1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    wr_cnt = rd_cnt;
    #1;
    chk("mid_occ_before", 32'(occupancy), 32'd2);
    @(negedge clk); #1;
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk_idle("mid_rst");
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; push(8'h55); #1;
    chk("refill_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("refill_valid", 32'(out_valid), 32'd1);
    chk("refill_data", 32'(out_data), 32'h55);
    @(negedge clk); #1;
    chk_idle("refill_done");

    // Random stress: random writes, 50% out_ready
    pushed = 0;
    n = 0;
    while (n < 6000 && (pushed < 500 || exp_q.size() != 0 || occupancy != 2'd0)) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (pushed < 500 && $urandom_range(0, 1) == 1) begin
        push(8'($urandom));
        pushed++;
      end
      n++;
    end
    chk("stress_pushed", 32'(pushed), 32'd500);
    chk("stress_drained", 32'(exp_q.size()), 32'd0);
    chk("stress_fifo_empty", 32'(fifo_empty), 32'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
